// File: rtl/phy_sync_handshake_tx.sv
// Source end of a toggle req/ack clock-domain crossing: one word in flight, held on req_data
// until the synchronized ack level matches req_toggle. Flags ack timeouts and stray acks.
module phy_sync_handshake_tx #(
    parameter int DATA_WIDTH     = 8,
    parameter int NUM_FLOPS      = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  req_toggle,
    output logic [DATA_WIDTH-1:0] req_data,
    input  logic                  ack_toggle_async,
    output logic                  xfer_done,
    output logic                  busy,
    output logic                  timeout_err,
    output logic                  protocol_err
);
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    logic [0:0]            state_q, state_d;
    logic                  req_tog_q, req_tog_d;
    logic [DATA_WIDTH-1:0] req_data_q, req_data_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  done_q, done_d;
    logic                  tmo_q, tmo_d;
    logic                  perr_q, perr_d;
    logic [NUM_FLOPS-1:0]  ack_sync_q;
    logic                  ack_s;

    assign ack_s = ack_sync_q[NUM_FLOPS-1];

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            ack_sync_q <= '0;
        end else begin
            ack_sync_q <= {ack_sync_q[NUM_FLOPS-2:0], ack_toggle_async};
        end
    end

    always_comb begin
        state_d    = state_q;
        req_tog_d  = req_tog_q;
        req_data_d = req_data_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        tmo_d      = 1'b0;
        perr_d     = perr_q;
        case (state_q)
            ST_IDLE: begin
                // In IDLE the far side has nothing to acknowledge, so any mismatch is a stray ack.
                if (ack_s != req_tog_q) begin
                    perr_d = 1'b1;
                end
                if (in_valid) begin
                    req_data_d = in_data;
                    req_tog_d  = ~req_tog_q;
                    cnt_d      = '0;
                    state_d    = ST_WAIT;
                end
            end
            default: begin
                if (ack_s == req_tog_q) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else if ((TIMEOUT_CYCLES > 0) && (cnt_q != CNT_MAX)) begin
                    // Saturating count: the pulse fires only on the step onto CNT_MAX.
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_MAX - 1'b1) begin
                        tmo_d = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            req_tog_q  <= 1'b0;
            req_data_q <= '0;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            tmo_q      <= 1'b0;
            perr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_tog_q  <= req_tog_d;
            req_data_q <= req_data_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            tmo_q      <= tmo_d;
            perr_q     <= perr_d;
        end
    end

    assign in_ready     = (state_q == ST_IDLE);
    assign busy         = (state_q == ST_WAIT);
    assign req_toggle   = req_tog_q;
    assign req_data     = req_data_q;
    assign xfer_done    = done_q;
    assign timeout_err  = tmo_q;
    assign protocol_err = perr_q;

endmodule
